button_cmd_arbiter: RTL and testbench
=====================================

// Module: button_cmd_arbiter
// PURPOSE
//  Front-panel input controller for the generator. Synchronises and debounces
//  N_BTN raw push-buttons, detects presses, produces hold-to-repeat events and
//  round-robin arbitrates all pending events onto one valid/ready command
//  stream feeding the generator settings logic (freq/amp/mode registers).
// PARAMETERS
//  N_BTN         4      number of buttons (>=2)
//  DEB_CYCLES    50000  consecutive stable cycles required to accept a new level
//  HOLD_CYCLES   25e6   cycles a press must be held before the first repeat
//  REPEAT_CYCLES 5e6    cycles between subsequent repeats while held
//  CNT_W         25     counter width; must hold max(DEB,HOLD,REPEAT)_CYCLES-1
//  ID_W          2      width of cmd_id; must be >= clog2(N_BTN)
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  btn_in      in   N_BTN  raw button levels, asynchronous, 1 = pressed
//  cmd_ready   in   1      consumer accepts command when cmd_valid & cmd_ready
//  cmd_valid   out  1      command available
//  cmd_id      out  ID_W   index of button that produced the command
//  cmd_repeat  out  1      0 = initial press, 1 = auto-repeat event
//  btn_level   out  N_BTN  debounced button levels
//  ovf         out  N_BTN  1-cycle pulse: event for button i dropped (pending full)
// BEHAVIOUR
//  Reset (rst_n=0, async): cmd_valid=0, cmd_id=0, cmd_repeat=0, btn_level=0,
//   ovf=0; sync flops, counters, pending bits cleared; all FSMs IDLE; RR
//   pointer set so button 0 has top priority. In-flight command is discarded.
//  Sync: 2-flop synchroniser per button; its output is sync[i].
//  Debounce: per-button counter; cycles with sync[i]==btn_level[i] clear it;
//   otherwise it increments; when counter==DEB_CYCLES-1 and sync still
//   differs, btn_level[i] toggles and counter clears. Glitches shorter than
//   DEB_CYCLES never change btn_level.
//  Repeat FSM per button, timer of CNT_W bits:
//   IDLE  : btn_level rises -> HOLD, timer=0, post event(rep=0).
//   HOLD  : btn_level low -> IDLE; timer==HOLD_CYCLES-1 -> REPEAT, timer=0,
//           post event(rep=1); else timer++.
//   REPEAT: btn_level low -> IDLE; timer==REPEAT_CYCLES-1 -> timer=0, post
//           event(rep=1); else timer++.
//   Release check has priority over timer expiry in the same cycle.
//  Pending: one pending bit + rep bit per button. Post sets pending on the
//   next edge (btn_level rises at edge E -> pending set at E+1). Post while
//   pending already set and not granted this cycle: event dropped, stored rep
//   kept, ovf[i]=1 for one cycle. Post in same cycle as grant of that button:
//   new event stored (set wins over clear), no ovf.
//  Arbiter/output register: loads when cmd_valid==0 or cmd_valid&cmd_ready.
//   Search starts at last_grant+1 and wraps modulo N_BTN; first pending button
//   is granted: cmd_id/cmd_repeat loaded, cmd_valid=1, its pending cleared,
//   last_grant updated. No pending -> cmd_valid=0 after handshake.
//   Idle latency: pending at E+1 -> cmd_valid at E+2. Back-to-back: one
//   command per cycle when cmd_ready stays 1.
//  While cmd_valid & !cmd_ready: cmd_id, cmd_repeat held stable; no grants.
//  Button held across reset release: btn_level starts 0, rises after
//   2+DEB_CYCLES cycles and produces a normal rep=0 event.
// TESTING (bench: DEB=8, HOLD=20, REPEAT=10, N_BTN=4)
//  Bounce: btn_in[0] toggles every 3 cycles for 40 cycles then stays 1,
//   ready=1 -> btn_level[0] rises once; exactly one cmd (id=0, rep=0).
//  Hold: btn_in[1] held 60 cycles, ready=1 -> cmd id=1 rep=0, then rep=1 at
//   +20 cycles, then rep=1 every 10 cycles; none after release.
//  Simultaneous: btn 1 and 2 reach btn_level same cycle after last_grant=2,
//   ready=1 -> id=1 then id=2 on consecutive cycles.
//  Backpressure: ready=0, btn_in[3] held -> cmd_valid=1 id=3 rep=0 stable;
//   first repeat pends, second repeat gives ovf[3] pulse; ready=1 -> rep=0
//   then rep=1 accepted on consecutive cycles.
//  Reset mid-op: rst_n=0 while cmd_valid=1 and btn_in[2] held -> cmd_valid,
//   btn_level, ovf go 0 immediately; after release one cmd id=2 rep=0 at
//   2+DEB+2 cycles.

Source files
------------

// File: rtl/button_cmd_arbiter.sv
// Purpose : synchronise/debounce N_BTN buttons, generate press and hold-to-repeat events, round-robin them onto one command stream.
// Latency : debounced level rises at edge E -> event pending at E+1 -> cmd_valid at E+2 (idle arbiter).
// Backpress: cmd_valid & !cmd_ready holds cmd_id/cmd_repeat and stops grants; one event per button queues, further ones pulse ovf.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn_in     raw asynchronous button levels (1 = pressed)
//   cmd_ready  consumer ready; command accepted on cmd_valid & cmd_ready
//   cmd_valid  command available
//   cmd_id     index of the button that produced the command
//   cmd_repeat 0 = initial press, 1 = auto-repeat
//   btn_level  debounced button levels
//   ovf        one-cycle pulse per button when an event was dropped
module button_cmd_arbiter #(
  parameter int N_BTN         = 4,
  parameter int DEB_CYCLES    = 50000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25,
  parameter int ID_W          = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic             cmd_repeat,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] ovf
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_MAX  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_BTN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_st_e;

  // Synchroniser and debounce state
  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] deb_cnt_q [N_BTN];
  logic [CNT_W-1:0] deb_cnt_d [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;

  // Repeat FSM state
  rpt_st_e          st_q  [N_BTN];
  rpt_st_e          st_d  [N_BTN];
  logic [CNT_W-1:0] tmr_q [N_BTN];
  logic [CNT_W-1:0] tmr_d [N_BTN];
  logic [N_BTN-1:0] post, post_rep;

  // Pending events and arbiter/output register
  logic [N_BTN-1:0] pend_q, pend_d, prep_q, prep_d;
  logic [N_BTN-1:0] grant, ovf_d, ovf_q, post_keep;
  logic             arb_load, arb_found;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_rep_q, cmd_rep_d;
  logic [ID_W-1:0]  cmd_id_q, cmd_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;

  // Debounce: count consecutive cycles the synchronised input disagrees
  // with the accepted level; accept the new level after DEB_CYCLES of them.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Repeat FSM. Being in IDLE with the level high can only mean the level
  // just rose, so that is the press event. Release beats timer expiry.
  always_comb begin
    post     = '0;
    post_rep = '0;
    for (int i = 0; i < N_BTN; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (level_q[i]) begin
            st_d[i]  = ST_HOLD;
            tmr_d[i] = '0;
            post[i]  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!level_q[i]) begin
            st_d[i] = ST_IDLE;
          end else if (tmr_q[i] == HOLD_MAX) begin
            st_d[i]     = ST_REPEAT;
            tmr_d[i]    = '0;
            post[i]     = 1'b1;
            post_rep[i] = 1'b1;
          end else begin
            tmr_d[i] = tmr_q[i] + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!level_q[i]) begin
            st_d[i] = ST_IDLE;
          end else if (tmr_q[i] == RPT_MAX) begin
            tmr_d[i]    = '0;
            post[i]     = 1'b1;
            post_rep[i] = 1'b1;
          end else begin
            tmr_d[i] = tmr_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]  = ST_IDLE;
          tmr_d[i] = '0;
        end
      endcase
    end
  end

  // Round-robin: first look above last_grant, then wrap from button 0.
  always_comb begin
    arb_load     = !cmd_valid_q || cmd_ready;
    arb_found    = 1'b0;
    grant        = '0;
    cmd_valid_d  = cmd_valid_q;
    cmd_id_d     = cmd_id_q;
    cmd_rep_d    = cmd_rep_q;
    last_grant_d = last_grant_q;
    if (arb_load) begin
      cmd_valid_d = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        if (!arb_found && pend_q[i] && (ID_W'(i) > last_grant_q)) begin
          arb_found    = 1'b1;
          grant[i]     = 1'b1;
          cmd_valid_d  = 1'b1;
          cmd_id_d     = ID_W'(i);
          cmd_rep_d    = prep_q[i];
          last_grant_d = ID_W'(i);
        end
      end
      for (int i = 0; i < N_BTN; i++) begin
        if (!arb_found && pend_q[i]) begin
          arb_found    = 1'b1;
          grant[i]     = 1'b1;
          cmd_valid_d  = 1'b1;
          cmd_id_d     = ID_W'(i);
          cmd_rep_d    = prep_q[i];
          last_grant_d = ID_W'(i);
        end
      end
    end
  end

  // A new event overwrites the slot unless the slot is occupied and not
  // being drained this cycle; in that case the event is lost and flagged.
  always_comb begin
    ovf_d     = post & pend_q & ~grant;
    post_keep = post & ~ovf_d;
    pend_d    = (pend_q & ~grant) | post;
    prep_d    = (prep_q & ~post_keep) | (post_rep & post_keep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      pend_q       <= '0;
      prep_q       <= '0;
      ovf_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= '0;
      cmd_rep_q    <= 1'b0;
      last_grant_q <= LAST_ID;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i] <= '0;
        st_q[i]      <= ST_IDLE;
        tmr_q[i]     <= '0;
      end
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      pend_q       <= pend_d;
      prep_q       <= prep_d;
      ovf_q        <= ovf_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      cmd_rep_q    <= cmd_rep_d;
      last_grant_q <= last_grant_d;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        st_q[i]      <= st_d[i];
        tmr_q[i]     <= tmr_d[i];
      end
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_id     = cmd_id_q;
  assign cmd_repeat = cmd_rep_q;
  assign btn_level  = level_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_button_cmd_arbiter.sv
// Bench for button_cmd_arbiter with short debounce/hold/repeat timings.
// Directed scenarios plus randomized buttons/ready against a behavioural model.
// Every cycle the model's command stream, levels and overflow pulses are compared.
module tb_button_cmd_arbiter;

  localparam int N    = 4;
  localparam int DEB  = 8;
  localparam int HOLD = 20;
  localparam int REP  = 10;
  localparam int CW   = 8;
  localparam int IW   = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_repeat;
  logic [3:0] btn_level;
  logic [3:0] ovf;

  button_cmd_arbiter #(
    .N_BTN(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .CNT_W(CW), .ID_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_repeat(cmd_repeat),
    .btn_level(btn_level), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cycle  = 0;
  int rel_base = 0;
  int ovf_cnt  = 0;
  int rise0    = 0;
  logic prev_lvl0 = 1'b0;

  typedef struct {
    int   cyc;
    int   id;
    logic rep;
  } acc_t;
  acc_t acc_q[$];

  // Behavioural model state
  logic [3:0]     m_s1, m_s2, m_lvl, m_pend, m_prep, m_ovf;
  logic [DEB-1:0] m_hist [4];
  int             m_hcnt [4];
  int             m_age  [4];
  logic           m_vld, m_rep;
  logic [1:0]     m_id;
  int             m_lg;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_prep = '0; m_ovf = '0;
    m_vld = 1'b0; m_rep = 1'b0; m_id = '0; m_lg = N - 1;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = '0; m_hcnt[i] = 0; m_age[i] = 0;
    end
  endtask

  // One clock edge of the model, all decisions taken from pre-edge state.
  task automatic model_edge();
    logic [3:0] post, prep_new, grant;
    int sel, j;
    logic nl;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // Events: press at age 0, first repeat at HOLD, then every REP cycles.
    for (int i = 0; i < N; i++) begin
      post[i] = m_lvl[i] && (m_age[i] == 0 || m_age[i] == HOLD ||
                (m_age[i] > HOLD && ((m_age[i] - HOLD) % REP) == 0));
      prep_new[i] = (m_age[i] != 0);
    end
    grant = '0;
    if (!m_vld || cmd_ready) begin
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_lg + k) % N;
        if (sel < 0 && m_pend[j[1:0]]) sel = j;
      end
      if (sel >= 0) begin
        grant[sel[1:0]] = 1'b1;
        m_vld = 1'b1;
        m_id  = sel[1:0];
        m_rep = m_prep[sel[1:0]];
        m_lg  = sel;
      end else begin
        m_vld = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_ovf[i] = 1'b0;
      if (post[i]) begin
        if (m_pend[i] && !grant[i]) m_ovf[i] = 1'b1;
        else begin
          m_pend[i] = 1'b1;
          m_prep[i] = prep_new[i];
        end
      end else if (grant[i]) begin
        m_pend[i] = 1'b0;
      end
    end
    // Debounce: level flips when the last DEB synchronised samples all disagree.
    for (int i = 0; i < N; i++) begin
      m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
      if (m_hcnt[i] < DEB) m_hcnt[i]++;
      nl = m_lvl[i];
      if (m_hcnt[i] == DEB && m_hist[i] == {DEB{~m_lvl[i]}}) nl = ~m_lvl[i];
      if (nl) m_age[i] = m_lvl[i] ? m_age[i] + 1 : 0;
      m_lvl[i] = nl;
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  // One cycle: check DUT against model at negedge, drive inputs, advance.
  task automatic step(input logic [3:0] b, input logic r);
    @(negedge clk);
    n_chk++;
    if (cmd_valid !== m_vld) begin
      n_fail++;
      $display("FAIL cyc_valid @%0d: got %b expected %b", cycle, cmd_valid, m_vld);
    end
    if (m_vld) begin
      n_chk++;
      if (cmd_id !== m_id || cmd_repeat !== m_rep) begin
        n_fail++;
        $display("FAIL cyc_cmd @%0d: got id=%0d rep=%b expected id=%0d rep=%b",
                 cycle, cmd_id, cmd_repeat, m_id, m_rep);
      end
    end
    n_chk++;
    if (btn_level !== m_lvl) begin
      n_fail++;
      $display("FAIL cyc_level @%0d: got %b expected %b", cycle, btn_level, m_lvl);
    end
    n_chk++;
    if (ovf !== m_ovf) begin
      n_fail++;
      $display("FAIL cyc_ovf @%0d: got %b expected %b", cycle, ovf, m_ovf);
    end
    ovf_cnt += $countones(ovf);
    if (btn_level[0] && !prev_lvl0) rise0++;
    prev_lvl0 = btn_level[0];
    btn_in    = b;
    cmd_ready = r;
    if (cmd_valid && r) begin
      acc_t a;
      a.cyc = cycle - rel_base;
      a.id  = int'(cmd_id);
      a.rep = cmd_repeat;
      acc_q.push_back(a);
    end
    @(posedge clk);
    model_edge();
    cycle++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_in = '0; cmd_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (cmd_valid !== 1'b0 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cmd: got v=%b id=%0d rep=%b expected 0/0/0", cmd_valid, cmd_id, cmd_repeat);
    end
    n_chk++;
    if (btn_level !== 4'b0 || ovf !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_level_ovf: got lvl=%b ovf=%b expected 0000/0000", btn_level, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bounce();
    acc_q.delete(); rise0 = 0;
    for (int c = 0; c < 40; c++) step({3'b000, ((c / 3) % 2 == 0)}, 1'b1);
    repeat (16) step(4'b0001, 1'b1);
    repeat (30) step(4'b0000, 1'b1);
    n_chk++;
    if (rise0 != 1) begin
      n_fail++;
      $display("FAIL bounce_rises: got %0d expected 1", rise0);
    end
    n_chk++;
    if (acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL bounce_cmds: got %0d expected 1", acc_q.size());
    end else begin
      n_chk++;
      if (acc_q[0].id != 0 || acc_q[0].rep !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_cmd: got id=%0d rep=%b expected id=0 rep=0", acc_q[0].id, acc_q[0].rep);
      end
    end
  endtask

  task automatic test_hold();
    int gaps [4] = '{20, 10, 10, 10};
    acc_q.delete();
    repeat (60) step(4'b0010, 1'b1);
    repeat (40) step(4'b0000, 1'b1);
    n_chk++;
    if (acc_q.size() != 5) begin
      n_fail++;
      $display("FAIL hold_cmds: got %0d expected 5", acc_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (acc_q[k].id != 1 || acc_q[k].rep !== (k != 0)) begin
          n_fail++;
          $display("FAIL hold_cmd%0d: got id=%0d rep=%b expected id=1 rep=%b",
                   k, acc_q[k].id, acc_q[k].rep, (k != 0));
        end
        if (k > 0) begin
          n_chk++;
          if (acc_q[k].cyc - acc_q[k-1].cyc != gaps[k-1]) begin
            n_fail++;
            $display("FAIL hold_gap%0d: got %0d expected %0d", k,
                     acc_q[k].cyc - acc_q[k-1].cyc, gaps[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    repeat (12) step(4'b0100, 1'b1);
    repeat (25) step(4'b0000, 1'b1);
    acc_q.delete();
    repeat (12) step(4'b0110, 1'b1);
    repeat (25) step(4'b0000, 1'b1);
    n_chk++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL simul_cmds: got %0d expected 2", acc_q.size());
    end else begin
      n_chk++;
      if (acc_q[0].id != 1 || acc_q[1].id != 2 || acc_q[1].cyc - acc_q[0].cyc != 1) begin
        n_fail++;
        $display("FAIL simul_order: got ids %0d,%0d gap %0d expected 1,2 gap 1",
                 acc_q[0].id, acc_q[1].id, acc_q[1].cyc - acc_q[0].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic seen = 1'b0;
    acc_q.delete(); ovf_cnt = 0;
    for (int k = 0; k < 150 && !seen; k++) begin
      step(4'b1000, 1'b0);
      if (ovf_cnt > 0) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_ovf_timeout: got no ovf expected ovf[3] pulse");
    end
    #1;
    n_chk++;
    if (cmd_valid !== 1'b1 || cmd_id !== 2'd3 || cmd_repeat !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_held: got v=%b id=%0d rep=%b expected 1/3/0", cmd_valid, cmd_id, cmd_repeat);
    end
    repeat (40) step(4'b0000, 1'b1);
    n_chk++;
    if (ovf_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_ovf_count: got %0d expected 1", ovf_cnt);
    end
    n_chk++;
    if (acc_q.size() < 2) begin
      n_fail++;
      $display("FAIL bp_cmds: got %0d expected at least 2", acc_q.size());
    end else if (acc_q[0].id != 3 || acc_q[0].rep !== 1'b0 || acc_q[1].id != 3 ||
                 acc_q[1].rep !== 1'b1 || acc_q[1].cyc - acc_q[0].cyc != 1) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d/%b %0d/%b gap %0d expected 3/0 3/1 gap 1",
               acc_q[0].id, acc_q[0].rep, acc_q[1].id, acc_q[1].rep, acc_q[1].cyc - acc_q[0].cyc);
    end
  endtask

  task automatic test_reset_midop();
    logic got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      step(4'b0100, 1'b0);
      #1;
      if (cmd_valid) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL midrst_timeout: got no cmd_valid expected 1");
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (cmd_valid !== 1'b0 || btn_level !== 4'b0 || ovf !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b lvl=%b ovf=%b expected 0/0000/0000", cmd_valid, btn_level, ovf);
    end
    model_reset();
    repeat (3) step(4'b0100, 1'b1);
    #2;
    rst_n = 1'b1;
    rel_base = cycle;
    acc_q.delete();
    repeat (20) step(4'b0100, 1'b1);
    n_chk++;
    if (acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL midrst_cmds: got %0d expected 1", acc_q.size());
    end else begin
      n_chk++;
      if (acc_q[0].cyc != 2 + DEB + 2 || acc_q[0].id != 2 || acc_q[0].rep !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_cmd: got cyc=%0d id=%0d rep=%b expected cyc=%0d id=2 rep=0",
                 acc_q[0].cyc, acc_q[0].id, acc_q[0].rep, 2 + DEB + 2);
      end
    end
    rel_base = 0;
    repeat (20) step(4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] b = '0;
    logic r;
    acc_q.delete();
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      r = ($urandom_range(0, 9) < 7);
      step(b, r);
    end
    repeat (60) step(4'b0000, 1'b1);
    n_chk++;
    if (acc_q.size() == 0) begin
      n_fail++;
      $display("FAIL random_activity: got 0 commands expected some");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bounce();
    test_hold();
    test_simultaneous();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
